// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer:
// opcodes, ALU ops, RF write sources, NPC selects, FSM and class enums.
package ctrl_pkg;

  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MDR = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;
  localparam logic [1:0] RS_IMM = 2'b11;

  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JALR = 3'b011;
  localparam logic [2:0] NPC_BEQ  = 3'b100;
  localparam logic [2:0] NPC_BNE  = 3'b101;
  localparam logic [2:0] NPC_BLT  = 3'b110;
  localparam logic [2:0] NPC_BGE  = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CL_I,
    CL_R,
    CL_S,
    CL_L,
    CL_B,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_BAD
  } cls_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/funct decode into class, ALU op,
// RF write source and branch NPC select.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [3:0] funct,
  output cls_e       cls,
  output logic       alu_src,
  output logic [3:0] alu_op,
  output logic [1:0] reg_src,
  output logic [2:0] br_npc
);

  logic [3:0] r_op;
  logic [3:0] i_op;

  always_comb begin
    cls = CL_BAD;
    unique case (1'b1)
      (opcode == OP_I):    cls = CL_I;
      (opcode == OP_R):    cls = CL_R;
      (opcode == OP_S):    cls = CL_S;
      (opcode == OP_L):    cls = CL_L;
      (opcode == OP_B):    cls = CL_B;
      (opcode == OP_JAL):  cls = CL_JAL;
      (opcode == OP_JALR): cls = CL_JALR;
      (opcode == OP_LUI):  cls = CL_LUI;
      default:             cls = CL_BAD;
    endcase
  end

  always_comb begin
    r_op = ALU_ADD;
    unique case (funct)
      4'b0000: r_op = ALU_ADD;
      4'b1000: r_op = ALU_SUB;
      4'b0111: r_op = ALU_AND;
      4'b0110: r_op = ALU_OR;
      4'b0100: r_op = ALU_XOR;
      4'b0001: r_op = ALU_SLL;
      4'b0101: r_op = ALU_SRL;
      4'b1101: r_op = ALU_SRA;
      default: r_op = ALU_ADD;
    endcase
  end

  // funct[3] is an immediate bit for I-type except on shifts
  always_comb begin
    i_op = ALU_ADD;
    unique case (funct[2:0])
      3'b111:  i_op = ALU_AND;
      3'b110:  i_op = ALU_OR;
      3'b100:  i_op = ALU_XOR;
      3'b001:  i_op = ALU_SLL;
      3'b101:  i_op = funct[3] ? ALU_SRA : ALU_SRL;
      default: i_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    reg_src = RS_ALU;
    br_npc  = NPC_BEQ;
    unique case (cls)
      CL_R: begin
        alu_op  = r_op;
        alu_src = 1'b1;
      end
      CL_I:    alu_op = i_op;
      CL_B: begin
        alu_op  = ALU_SUB;
        alu_src = 1'b1;
      end
      CL_L:    reg_src = RS_MDR;
      CL_JAL:  reg_src = RS_PC4;
      CL_JALR: reg_src = RS_PC4;
      CL_LUI:  reg_src = RS_IMM;
      default: alu_op = ALU_ADD;
    endcase
    unique case (funct[2:0])
      3'b001:  br_npc = NPC_BNE;
      3'b100:  br_npc = NPC_BLT;
      3'b101:  br_npc = NPC_BGE;
      default: br_npc = NPC_BEQ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with one-shot
// write strobes, memory-wait timeout trap and retire counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [3:0]       funct,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_write,
  output logic             dmem_req,
  input  logic             dmem_ready,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             ctrl_ALU_input,
  output logic [3:0]       ctrl_ALU_output,
  output logic             ctrl_DRAM_write,
  output logic [1:0]       ctrl_Reg_input,
  output logic             ctrl_Reg_write,
  output logic [2:0]       ctrl_NPC_output,
  output logic             trap,
  output logic [RET_W-1:0] retired
);

  localparam int TW = $clog2(TIMEOUT);

  cls_e       dec_cls;
  logic       dec_alu_src;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_reg_src;
  logic [2:0] dec_br_npc;

  instr_decode u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .alu_src (dec_alu_src),
    .alu_op  (dec_alu_op),
    .reg_src (dec_reg_src),
    .br_npc  (dec_br_npc)
  );

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic             alu_src_q, alu_src_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [1:0]       reg_src_q, reg_src_d;
  logic [2:0]       br_npc_q, br_npc_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             trap_q, trap_d;
  logic [RET_W-1:0] retired_q, retired_d;

  logic       imem_req_c, ir_write_c, dmem_req_c;
  logic       mdr_write_c, pc_write_c, dram_we_c;
  logic       reg_we_c, alu_in_c, wait_c;
  logic [3:0] alu_op_c;
  logic [1:0] reg_in_c;
  logic [2:0] npc_c;

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    alu_src_d   = alu_src_q;
    alu_op_d    = alu_op_q;
    reg_src_d   = reg_src_q;
    br_npc_d    = br_npc_q;
    tmo_d       = tmo_q;
    trap_d      = trap_q;
    retired_d   = retired_q;
    imem_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    dmem_req_c  = 1'b0;
    mdr_write_c = 1'b0;
    pc_write_c  = 1'b0;
    dram_we_c   = 1'b0;
    reg_we_c    = 1'b0;
    alu_in_c    = 1'b0;
    alu_op_c    = '0;
    reg_in_c    = '0;
    npc_c       = '0;
    wait_c      = 1'b0;

    if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
      alu_in_c = alu_src_q;
      alu_op_c = alu_op_q;
    end

    unique case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          tmo_d      = '0;
          state_d    = ST_DECODE;
        end else begin
          wait_c = 1'b1;
        end
      end
      ST_DECODE: begin
        cls_d     = dec_cls;
        alu_src_d = dec_alu_src;
        alu_op_d  = dec_alu_op;
        reg_src_d = dec_reg_src;
        br_npc_d  = dec_br_npc;
        state_d   = (dec_cls == CL_BAD) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        if (cls_q == CL_B) begin
          pc_write_c = 1'b1;
          npc_c      = br_npc_q;
          state_d    = ST_FETCH;
        end else if (cls_q == CL_S || cls_q == CL_L) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        dram_we_c  = (cls_q == CL_S);
        if (dmem_ready) begin
          tmo_d = '0;
          if (cls_q == CL_S) begin
            pc_write_c = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            mdr_write_c = 1'b1;
            state_d     = ST_WB;
          end
        end else begin
          wait_c = 1'b1;
        end
      end
      ST_WB: begin
        reg_we_c   = 1'b1;
        pc_write_c = 1'b1;
        reg_in_c   = reg_src_q;
        npc_c      = (cls_q == CL_JAL)  ? NPC_JAL  :
                     (cls_q == CL_JALR) ? NPC_JALR : NPC_SEQ;
        state_d    = ST_FETCH;
      end
      ST_TRAP: trap_d = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    // ready in the final allowed wait cycle still completes
    if (wait_c) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        tmo_d   = '0;
        state_d = ST_TRAP;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (state_d == ST_TRAP) trap_d = 1'b1;
    if (pc_write_c) retired_d = retired_q + RET_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CL_I;
      alu_src_q <= 1'b0;
      alu_op_q  <= '0;
      reg_src_q <= '0;
      br_npc_q  <= '0;
      tmo_q     <= '0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_src_q <= alu_src_d;
      alu_op_q  <= alu_op_d;
      reg_src_q <= reg_src_d;
      br_npc_q  <= br_npc_d;
      tmo_q     <= tmo_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req        = rst_n & imem_req_c;
  assign ir_write        = rst_n & ir_write_c;
  assign dmem_req        = rst_n & dmem_req_c;
  assign mdr_write       = rst_n & mdr_write_c;
  assign pc_write        = rst_n & pc_write_c;
  assign ctrl_ALU_input  = rst_n & alu_in_c;
  assign ctrl_ALU_output = rst_n ? alu_op_c : '0;
  assign ctrl_DRAM_write = rst_n & dram_we_c;
  assign ctrl_Reg_input  = rst_n ? reg_in_c : '0;
  assign ctrl_Reg_write  = rst_n & reg_we_c;
  assign ctrl_NPC_output = rst_n ? npc_c : '0;
  assign trap            = rst_n & trap_q;
  assign retired         = rst_n ? retired_q : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a
// per-instruction transaction model.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [3:0]  funct = '0;
  logic        imem_req, imem_ready = 1'b0;
  logic        ir_write, dmem_req, dmem_ready = 1'b0;
  logic        mdr_write, pc_write, ctrl_ALU_input;
  logic [3:0]  ctrl_ALU_output;
  logic        ctrl_DRAM_write;
  logic [1:0]  ctrl_Reg_input;
  logic        ctrl_Reg_write;
  logic [2:0]  ctrl_NPC_output;
  logic        trap;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TMO), .RET_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .opcode          (opcode),
    .funct           (funct),
    .imem_req        (imem_req),
    .imem_ready      (imem_ready),
    .ir_write        (ir_write),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .mdr_write       (mdr_write),
    .pc_write        (pc_write),
    .ctrl_ALU_input  (ctrl_ALU_input),
    .ctrl_ALU_output (ctrl_ALU_output),
    .ctrl_DRAM_write (ctrl_DRAM_write),
    .ctrl_Reg_input  (ctrl_Reg_input),
    .ctrl_Reg_write  (ctrl_Reg_write),
    .ctrl_NPC_output (ctrl_NPC_output),
    .trap            (trap),
    .retired         (retired)
  );

  int total = 0;
  int bad = 0;
  longint exp_ret = 0;

  // class ids: 0 I,1 R,2 S,3 L,4 B,5 JAL,6 JALR,7 LUI,8 illegal
  logic [6:0] optab [8] = '{7'b0010011, 7'b0110011, 7'b0100011,
    7'b0000011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    for (int i = 0; i < 8; i++)
      if (optab[i] == op) return i;
    return 8;
  endfunction

  function automatic int m_alu(input int c, input logic [3:0] f);
    int r;
    r = 0;
    if (c == 1) begin
      case (f)
        4'b1000: r = 1;
        4'b0111: r = 2;
        4'b0110: r = 3;
        4'b0100: r = 4;
        4'b0001: r = 5;
        4'b0101: r = 6;
        4'b1101: r = 7;
        default: r = 0;
      endcase
    end else if (c == 0) begin
      case (f[2:0])
        3'b111:  r = 2;
        3'b110:  r = 3;
        3'b100:  r = 4;
        3'b001:  r = 5;
        3'b101:  r = f[3] ? 7 : 6;
        default: r = 0;
      endcase
    end else if (c == 4) begin
      r = 1;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {imem_req, ir_write, dmem_req, mdr_write, pc_write,
        ctrl_ALU_input, ctrl_ALU_output, ctrl_DRAM_write,
        ctrl_Reg_input, ctrl_Reg_write, ctrl_NPC_output, trap}, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_req", imem_req, 1);
    chk("rst_strobes", {ir_write, dmem_req, mdr_write, pc_write,
        ctrl_DRAM_write, ctrl_Reg_write, ctrl_NPC_output, trap}, 0);
    chk("rst_retired", retired, 0);
    exp_ret = 0;
  endtask

  // Starts in the low phase of a FETCH cycle; ends in the low phase
  // of the cycle after the instruction's last cycle (or after trap).
  task automatic run_instr(input logic [6:0] op, input logic [3:0] f,
                           input int fw, input int mw);
    int c, cyc, fc, mc;
    int nir, npw, nrw, ndw, nmdr, nidle;
    int e_cyc, e_dw;
    bit done, trapped, is_mem, e_trap, e_rw;
    logic [2:0] v_npc, e_npc;
    logic [1:0] v_rs, e_rs;
    logic [3:0] v_alu;
    logic v_alui;
    c = cls_of(op);
    cyc = 0; fc = 0; mc = 0;
    nir = 0; npw = 0; nrw = 0; ndw = 0; nmdr = 0; nidle = 0;
    done = 0; trapped = 0;
    v_npc = '0; v_rs = '0; v_alu = '0; v_alui = 1'b0;
    opcode = op;
    funct = f;
    while (!done && cyc < 60) begin
      cyc++;
      imem_ready = imem_req && (fc == fw);
      if (imem_req) fc++;
      dmem_ready = dmem_req && (mc == mw);
      if (dmem_req) mc++;
      #1;
      if (trap) begin
        trapped = 1;
        done = 1;
      end
      nir += int'(ir_write);
      nrw += int'(ctrl_Reg_write);
      ndw += int'(ctrl_DRAM_write);
      nmdr += int'(mdr_write);
      if (!pc_write && ctrl_NPC_output != 0) nidle++;
      if (ctrl_Reg_write) v_rs = ctrl_Reg_input;
      if (pc_write) begin
        npw++;
        v_npc = ctrl_NPC_output;
        v_alu = ctrl_ALU_output;
        v_alui = ctrl_ALU_input;
        done = 1;
      end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    is_mem = (c == 2 || c == 3);
    e_trap = (fw >= TMO) || (c == 8) || (is_mem && mw >= TMO);
    if (fw >= TMO) e_cyc = TMO + 1;
    else if (c == 8) e_cyc = fw + 3;
    else if (is_mem && mw >= TMO) e_cyc = fw + TMO + 4;
    else e_cyc = ((c == 4) ? 3 : (c == 3) ? 5 : 4) + fw
                 + (is_mem ? mw : 0);
    e_rw = !e_trap && (c == 0 || c == 1 || c == 3 ||
                       c == 5 || c == 6 || c == 7);
    e_dw = (c == 2 && fw < TMO) ? ((mw + 1 < TMO) ? mw + 1 : TMO) : 0;
    e_rs = (c == 3) ? 2'b01 : (c == 5 || c == 6) ? 2'b10 :
           (c == 7) ? 2'b11 : 2'b00;
    if (c == 4) e_npc = (f[2:0] == 3'b001) ? 3'b101 :
                        (f[2:0] == 3'b100) ? 3'b110 :
                        (f[2:0] == 3'b101) ? 3'b111 : 3'b100;
    else e_npc = (c == 5) ? 3'b010 : (c == 6) ? 3'b011 : 3'b000;

    chk("cycles", cyc, e_cyc);
    chk("trap", trapped, e_trap);
    chk("ir_write", nir, (fw >= TMO) ? 0 : 1);
    chk("pc_write", npw, e_trap ? 0 : 1);
    chk("reg_write", nrw, e_rw);
    chk("dram_write", ndw, e_dw);
    chk("mdr_write", nmdr, (c == 3 && !e_trap) ? 1 : 0);
    chk("npc_idle", nidle, 0);
    if (!e_trap) begin
      chk("npc_sel", v_npc, e_npc);
      chk("alu_op", v_alu, m_alu(c, f));
      chk("alu_src", v_alui, (c == 1 || c == 4) ? 1 : 0);
      if (e_rw) chk("reg_input", v_rs, e_rs);
      exp_ret++;
    end
    chk("retired", retired, exp_ret);
    if (e_trap) begin
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("trap_hold", {imem_req, ir_write, pc_write, trap}, 1);
        @(negedge clk);
      end
      do_reset();
    end
  endtask

  task automatic reset_in_sw_mem();
    opcode = optab[2];
    funct = 4'b0010;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("sw_mem_dw", ctrl_DRAM_write, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sw_rst_dw", ctrl_DRAM_write, 0);
    chk("sw_rst_req", imem_req, 1);
    chk("sw_rst_ret", retired, 0);
    exp_ret = 0;
  endtask

  initial begin
    logic [6:0] rop;
    int rc, rfw, rmw;
    do_reset();
    run_instr(optab[1], 4'b0000, 0, 0);
    run_instr(optab[3], 4'b0010, 0, 0);
    run_instr(optab[2], 4'b0010, 0, 0);
    run_instr(optab[4], 4'b0000, 0, 0);
    chk("prog_retired", retired, 4);
    run_instr(optab[1], 4'b1101, 0, 0);
    run_instr(optab[0], 4'b1101, 0, 0);
    run_instr(optab[0], 4'b0111, 0, 0);
    run_instr(optab[3], 4'b0010, 0, 3);
    run_instr(optab[5], 4'b0000, 0, 0);
    run_instr(optab[6], 4'b0000, 1, 0);
    run_instr(optab[7], 4'b0000, 0, 0);
    run_instr(optab[4], 4'b0101, 2, 0);
    run_instr(7'b0000000, 4'b0000, 0, 0);
    run_instr(optab[0], 4'b0000, 4, 0);
    run_instr(optab[0], 4'b0000, 3, 0);
    run_instr(optab[2], 4'b0010, 0, 4);
    run_instr(optab[3], 4'b0010, 1, 3);
    do_reset();
    reset_in_sw_mem();
    for (int n = 0; n < 300; n++) begin
      rc = $urandom_range(0, 99);
      if (rc < 4) begin
        rop = 7'($urandom_range(0, 127));
        while (cls_of(rop) != 8) rop = 7'($urandom_range(0, 127));
      end else begin
        rop = optab[rc % 8];
      end
      rfw = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, 3);
      rmw = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, 3);
      run_instr(rop, 4'($urandom_range(0, 15)), rfw, rmw);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
